// File: rtl/alu_decode_stage_pkg.sv
// Shared constants and the decoded-entry record for the ALU decode stage.
// Optional illegal-encoding detection is enabled with `define ALU_DECODE_ILLEGAL_EN.
package alu_decode_stage_pkg;

    localparam int LEN_WORD     = 32;
    localparam int LEN_FUNC3    = 3;
    localparam int LEN_REG_ADDR = 5;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

`ifdef ALU_DECODE_ILLEGAL_EN
    localparam logic [LEN_FUNC3-1:0] FUNC3_ADD  = 3'b000;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SL   = 3'b001;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SLT  = 3'b010;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SLTU = 3'b011;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SR   = 3'b101;
    localparam logic [6:0]           FUNCT7_BASE = 7'h00;
    localparam logic [6:0]           FUNCT7_ALT  = 7'h20;
`endif

    typedef struct packed {
        logic                    alu_en;
        logic [LEN_FUNC3-1:0]    func3;
        logic                    mode;
        logic                    imm_f;
        logic [LEN_REG_ADDR-1:0] rs1;
        logic [LEN_REG_ADDR-1:0] rs2;
        logic [LEN_REG_ADDR-1:0] rd;
        logic [LEN_WORD-1:0]     imm;
        logic [LEN_WORD-1:0]     inst;
`ifdef ALU_DECODE_ILLEGAL_EN
        logic                    illegal;
`endif
    } dec_entry_t;

    localparam int LEN_DEC_ENTRY = $bits(dec_entry_t);

endpackage

// File: rtl/alu_decode_stage_comb.sv
// Pure combinational RV32I OP/OP-IMM field decode into a dec_entry_t.
// With `define ALU_DECODE_ILLEGAL_EN, encodings the ALU cannot execute are flagged.
import alu_decode_stage_pkg::*;

module alu_decode_comb (
    input  logic [LEN_WORD-1:0] inst_i,
    output dec_entry_t          entry_o
);

    logic [6:0] opcode;
    logic       is_op;
    logic       is_imm;
`ifdef ALU_DECODE_ILLEGAL_EN
    logic [6:0] funct7;
    logic       is_shift;
    logic       illegal;
`endif

    assign opcode = inst_i[6:0];
    assign is_op  = (opcode == OPCODE_OP);
    assign is_imm = (opcode == OPCODE_OP_IMM);

`ifdef ALU_DECODE_ILLEGAL_EN
    assign funct7   = inst_i[31:25];
    assign is_shift = (inst_i[14:12] == FUNC3_SL) || (inst_i[14:12] == FUNC3_SR);

    always_comb begin
        illegal = 1'b0;
        if (inst_i[14:12] == FUNC3_SLT || inst_i[14:12] == FUNC3_SLTU) begin
            illegal = 1'b1;
        end
        if (is_op) begin
            if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
                illegal = 1'b1;
            end
            if (funct7 == FUNCT7_ALT && inst_i[14:12] != FUNC3_ADD && inst_i[14:12] != FUNC3_SR) begin
                illegal = 1'b1;
            end
        end
        // Shift-immediates reuse imm[11:5] as a funct7-like selector.
        if (is_imm && is_shift) begin
            if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
                illegal = 1'b1;
            end
            if (funct7 == FUNCT7_ALT && inst_i[14:12] == FUNC3_SL) begin
                illegal = 1'b1;
            end
        end
        if (!(is_op || is_imm)) begin
            illegal = 1'b0;
        end
    end
`endif

    always_comb begin
        entry_o.alu_en = is_op || is_imm;
        entry_o.func3  = inst_i[14:12];
        entry_o.mode   = inst_i[30];
        entry_o.imm_f  = is_imm;
        entry_o.rs1    = inst_i[19:15];
        entry_o.rs2    = is_imm ? '0 : inst_i[24:20];
        entry_o.rd     = inst_i[11:7];
        entry_o.imm    = is_op ? '0 : {{20{inst_i[31]}}, inst_i[31:20]};
        entry_o.inst   = inst_i;
`ifdef ALU_DECODE_ILLEGAL_EN
        entry_o.illegal = illegal;
        if (illegal) begin
            entry_o.alu_en = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage: decodes fetched words and registers them behind a valid/ready skid buffer.
// Define ALU_DECODE_ILLEGAL_EN to add the out_illegal output.
import alu_decode_stage_pkg::*;

module alu_decode_stage (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEN_WORD-1:0]     in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_alu_en,
    output logic [LEN_FUNC3-1:0]    out_func3,
    output logic                    out_mode,
    output logic                    out_imm_f,
    output logic [LEN_REG_ADDR-1:0] out_rs1,
    output logic [LEN_REG_ADDR-1:0] out_rs2,
    output logic [LEN_REG_ADDR-1:0] out_rd,
    output logic [LEN_WORD-1:0]     out_imm,
`ifdef ALU_DECODE_ILLEGAL_EN
    output logic                    out_illegal,
`endif
    output logic [LEN_WORD-1:0]     out_inst
);

    dec_entry_t dec_entry;
    dec_entry_t m_entry_q, m_entry_d;
    dec_entry_t s_entry_q, s_entry_d;
    logic       m_valid_q, m_valid_d;
    logic       s_valid_q, s_valid_d;
    logic       m_leave;
    logic       accept;

    alu_decode_comb u_decode (
        .inst_i  (in_inst),
        .entry_o (dec_entry)
    );

    // in_ready depends only on skid occupancy, so no comb path from out_ready.
    assign in_ready = ~s_valid_q;
    assign accept   = in_valid & ~s_valid_q;
    assign m_leave  = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_entry_d = m_entry_q;
        s_entry_d = s_entry_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_leave && s_valid_q) begin
            m_valid_d = 1'b1;
            m_entry_d = s_entry_q;
            s_valid_d = 1'b0;
        end else if (accept && (!m_valid_q || m_leave)) begin
            m_valid_d = 1'b1;
            m_entry_d = dec_entry;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_entry_d = dec_entry;
        end else if (m_leave) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_entry_q <= '0;
            s_entry_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_entry_q <= m_entry_d;
            s_entry_q <= s_entry_d;
        end
    end

    assign out_valid  = m_valid_q;
    assign out_alu_en = m_entry_q.alu_en;
    assign out_func3  = m_entry_q.func3;
    assign out_mode   = m_entry_q.mode;
    assign out_imm_f  = m_entry_q.imm_f;
    assign out_rs1    = m_entry_q.rs1;
    assign out_rs2    = m_entry_q.rs2;
    assign out_rd     = m_entry_q.rd;
    assign out_imm    = m_entry_q.imm;
    assign out_inst   = m_entry_q.inst;
`ifdef ALU_DECODE_ILLEGAL_EN
    assign out_illegal = m_entry_q.illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: decode vector table, skid/flush sequences,
// and a randomized stream checked against a queue-based reference model.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic        out_alu_en;
    logic [2:0]  out_func3;
    logic        out_mode;
    logic        out_imm_f;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_inst;
`ifdef ALU_DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    alu_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_en (out_alu_en),
        .out_func3  (out_func3),
        .out_mode   (out_mode),
        .out_imm_f  (out_imm_f),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
`ifdef ALU_DECODE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .out_inst   (out_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        alu_en;
        logic [2:0]  f3;
        logic        mode;
        logic        imm_f;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] q[$];
    logic [31:0] got[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Reference decode straight from the ISA field definitions.
    function automatic logic ref_illegal(input logic [31:0] w);
        int op = int'(w & 32'h7f);
        int f3 = int'((w >> 12) & 32'h7);
        int f7 = int'((w >> 25) & 32'h7f);
        logic ill = 1'b0;
        if (op != 'h33 && op != 'h13) return 1'b0;
        if (f3 == 2 || f3 == 3) ill = 1'b1;
        if (op == 'h33 && f7 != 0 && f7 != 'h20) ill = 1'b1;
        if (op == 'h33 && f7 == 'h20 && f3 != 0 && f3 != 5) ill = 1'b1;
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
            if (f7 != 0 && f7 != 'h20) ill = 1'b1;
            if (f7 == 'h20 && f3 == 1) ill = 1'b1;
        end
        return ill;
    endfunction

    task automatic check_entry(input logic [31:0] w);
        int   op = int'(w & 32'h7f);
        logic imm_f = (op == 'h13);
        logic alu = (op == 'h33) || imm_f;
`ifdef ALU_DECODE_ILLEGAL_EN
        check("illegal", 32'(out_illegal), 32'(ref_illegal(w)));
        if (ref_illegal(w)) alu = 1'b0;
`endif
        check("inst", out_inst, w);
        check("alu_en", 32'(out_alu_en), 32'(alu));
        if (alu) begin
            check("func3", 32'(out_func3), (w >> 12) & 32'h7);
            check("mode", 32'(out_mode), (w >> 30) & 32'h1);
            check("imm_f", 32'(out_imm_f), 32'(imm_f));
            check("rs1", 32'(out_rs1), (w >> 15) & 32'h1f);
            check("rs2", 32'(out_rs2), imm_f ? 32'h0 : ((w >> 20) & 32'h1f));
            check("rd", 32'(out_rd), (w >> 7) & 32'h1f);
            check("imm", out_imm, (op == 'h33) ? 32'h0 : 32'($signed(w) >>> 20));
        end
    endtask

    // Called at a negedge: check DUT against the model, drive inputs, advance one cycle.
    task automatic step(input logic iv, input logic [31:0] w, input logic orr, input logic fl);
        logic can_in;
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) check_entry(q[0]);
        in_valid  = iv;
        in_inst   = w;
        out_ready = orr;
        flush     = fl;
        can_in    = (q.size() < 2);
        if (fl) q.delete();
        else begin
            if (orr && q.size() > 0) void'(q.pop_front());
            if (iv && can_in) q.push_back(w);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        logic [6:0]  f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                          ($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00);
        case ($urandom_range(0, 3))
            0: begin w[6:0] = 7'h33; w[31:25] = f7; end
            1: w[6:0] = 7'h13;
            2: ;
            default: begin
                w[6:0] = 7'h13;
                w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                w[31:25] = f7;
            end
        endcase
        return w;
    endfunction

    initial begin
        int ready_low;
        int idx;
        logic acc;
        logic orr;

        vecs[0] = '{32'h002081B3, 1, 3'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'h0, 0};
        vecs[1] = '{32'h407302B3, 1, 3'd0, 1, 0, 5'd6, 5'd7, 5'd5, 32'h0, 0};
        vecs[2] = '{32'hFFF00093, 1, 3'd0, 1, 1, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 0};
        vecs[3] = '{32'h40315113, 1, 3'd5, 1, 1, 5'd2, 5'd0, 5'd2, 32'h00000403, 0};
`ifdef ALU_DECODE_ILLEGAL_EN
        vecs[4] = '{32'h00002013, 0, 3'd2, 0, 1, 5'd0, 5'd0, 5'd0, 32'h0, 1};
`else
        vecs[4] = '{32'h00002013, 1, 3'd2, 0, 1, 5'd0, 5'd0, 5'd0, 32'h0, 0};
`endif
        vecs[5] = '{32'h003110B3, 1, 3'd1, 0, 0, 5'd2, 5'd3, 5'd1, 32'h0, 0};
        vecs[6] = '{32'h8A52F213, 1, 3'd7, 0, 1, 5'd5, 5'd0, 5'd4, 32'hFFFFF8A5, 0};
        vecs[7] = '{32'h00002083, 0, 3'd2, 0, 0, 5'd0, 5'd0, 5'd1, 32'h0, 0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h1);
        check("rst out_inst", out_inst, 32'h0);
        check("rst out_imm", out_imm, 32'h0);
        check("rst out_alu_en", 32'(out_alu_en), 32'h0);
        check("rst out_rd", 32'(out_rd), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].inst, 1'b1, 1'b0);
            check("tbl valid", 32'(out_valid), 32'h1);
            check("tbl inst", out_inst, vecs[i].inst);
            check("tbl alu_en", 32'(out_alu_en), 32'(vecs[i].alu_en));
`ifdef ALU_DECODE_ILLEGAL_EN
            check("tbl illegal", 32'(out_illegal), 32'(vecs[i].illegal));
`endif
            if (vecs[i].alu_en) begin
                check("tbl func3", 32'(out_func3), 32'(vecs[i].f3));
                check("tbl mode", 32'(out_mode), 32'(vecs[i].mode));
                check("tbl imm_f", 32'(out_imm_f), 32'(vecs[i].imm_f));
                check("tbl rs1", 32'(out_rs1), 32'(vecs[i].rs1));
                check("tbl rs2", 32'(out_rs2), 32'(vecs[i].rs2));
                check("tbl rd", 32'(out_rd), 32'(vecs[i].rd));
                check("tbl imm", out_imm, vecs[i].imm);
            end
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Stream 4 words with execute stalled for the first two cycles.
        got.delete(); idx = 0; ready_low = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            orr = (cyc >= 2);
            if (!in_ready) ready_low++;
            if (out_valid && orr) got.push_back(out_inst);
            acc = (idx < 4) && (q.size() < 2);
            step(idx < 4, (idx < 4) ? vecs[idx].inst : 32'h0, orr, 1'b0);
            if (acc) idx++;
        end
        check("stream count", 32'(got.size()), 32'd4);
        check("stream ready_low", 32'(ready_low), 32'd1);
        for (int i = 0; i < 4; i++)
            check("stream order", (i < got.size()) ? got[i] : 32'hDEADBEEF, vecs[i].inst);

        // Fill M and S, then flush while a new word is offered.
        step(1'b1, vecs[0].inst, 1'b0, 1'b0);
        step(1'b1, vecs[1].inst, 1'b0, 1'b0);
        check("full in_ready", 32'(in_ready), 32'h0);
        step(1'b1, vecs[2].inst, 1'b1, 1'b1);
        check("flush out_valid", 32'(out_valid), 32'h0);
        check("flush in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with both registers occupied.
        step(1'b1, vecs[3].inst, 1'b0, 1'b0);
        step(1'b1, vecs[5].inst, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'h0);
        check("async rst in_ready", 32'(in_ready), 32'h1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain out_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
